// File: rtl/slink_gpio_align_pkg.sv
// rtl/slink_gpio_align_pkg.sv - shared types and constants for the GPIO RX word aligner
package slink_gpio_align_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } align_state_e;

  localparam logic [7:0] DEFAULT_SYNC_PATTERN = 8'hB5;
  localparam int         MATCH_CNT_W          = 4;

endpackage

// File: rtl/slink_gpio_align_rotate.sv
// rtl/slink_gpio_align_rotate.sv - extracts every lane rotation of the two-word window and flags sync matches
module slink_gpio_align_rotate #(
  parameter int                        PAR_DATA_WIDTH = 8,
  parameter int                        IO_DATA_WIDTH  = 1,
  parameter int                        DIV_RATIO      = PAR_DATA_WIDTH / IO_DATA_WIDTH,
  parameter logic [PAR_DATA_WIDTH-1:0] SYNC_PATTERN   = '0
) (
  input  logic [2*PAR_DATA_WIDTH-1:0]                window,
  output logic [DIV_RATIO-1:0][PAR_DATA_WIDTH-1:0]   cand,
  output logic [DIV_RATIO-1:0]                       match
);

  for (genvar k = 0; k < DIV_RATIO; k++) begin : g_cand
    assign cand[k]  = window[k*IO_DATA_WIDTH +: PAR_DATA_WIDTH];
    assign match[k] = (cand[k] == SYNC_PATTERN);
  end

endmodule

// File: rtl/slink_gpio_rx_align.sv
// rtl/slink_gpio_rx_align.sv - GPIO serdes RX word aligner: search, qualify, lock rotation, deliver aligned words
// Optional status outputs (relock_cnt, verify_fail) built when SLINK_GPIO_RX_ALIGN_STATUS_EN is defined.
module slink_gpio_rx_align
  import slink_gpio_align_pkg::*;
#(
  parameter int                        PAR_DATA_WIDTH = 8,
  parameter int                        IO_DATA_WIDTH  = 1,
  parameter logic [PAR_DATA_WIDTH-1:0] SYNC_PATTERN   = PAR_DATA_WIDTH'(DEFAULT_SYNC_PATTERN),
  parameter int                        LOCK_COUNT     = 4,
  localparam int                       DIV_RATIO      = PAR_DATA_WIDTH / IO_DATA_WIDTH,
  localparam int                       SEL_W          = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      relock,
  input  logic [PAR_DATA_WIDTH-1:0] rx_par_data,
  output logic [PAR_DATA_WIDTH-1:0] rx_data,
  output logic                      rx_data_valid,
  output logic                      locked,
  output logic [SEL_W-1:0]          align_sel
`ifdef SLINK_GPIO_RX_ALIGN_STATUS_EN
  ,
  output logic [7:0]                relock_cnt,
  output logic                      verify_fail
`endif
);

  localparam logic [MATCH_CNT_W-1:0] LOCK_CNT = MATCH_CNT_W'(LOCK_COUNT);

  align_state_e                                 state, state_nxt;
  logic [PAR_DATA_WIDTH-1:0]                    prev_word;
  logic [MATCH_CNT_W-1:0]                       match_cnt, cnt_nxt;
  logic [SEL_W-1:0]                             sel_nxt, hit_sel;
  logic                                         hit_any, sel_match, lock_nxt;
  logic [PAR_DATA_WIDTH-1:0]                    data_nxt;
  logic [DIV_RATIO-1:0][PAR_DATA_WIDTH-1:0]     cand;
  logic [DIV_RATIO-1:0]                         match;

  slink_gpio_align_rotate #(
    .PAR_DATA_WIDTH (PAR_DATA_WIDTH),
    .IO_DATA_WIDTH  (IO_DATA_WIDTH),
    .DIV_RATIO      (DIV_RATIO),
    .SYNC_PATTERN   (SYNC_PATTERN)
  ) u_rotate (
    .window (({rx_par_data, prev_word})),
    .cand   (cand),
    .match  (match)
  );

  // Lowest matching rotation wins when the window happens to hold several.
  always_comb begin
    hit_any = 1'b0;
    hit_sel = '0;
    for (int k = DIV_RATIO - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit_any = 1'b1;
        hit_sel = SEL_W'(k);
      end
    end
  end

  assign sel_match = match[align_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      prev_word     <= '0;
      match_cnt     <= '0;
      align_sel     <= '0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      locked        <= 1'b0;
    end else begin
      state         <= state_nxt;
      prev_word     <= rx_par_data;
      match_cnt     <= cnt_nxt;
      align_sel     <= sel_nxt;
      rx_data       <= data_nxt;
      rx_data_valid <= lock_nxt;
      locked        <= lock_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = match_cnt;
    sel_nxt   = align_sel;
    unique case (state)
      ST_IDLE:   state_nxt = ST_SEARCH;
      ST_SEARCH: begin
        if (hit_any) begin
          sel_nxt   = hit_sel;
          cnt_nxt   = MATCH_CNT_W'(1);
          state_nxt = (LOCK_CNT == MATCH_CNT_W'(1)) ? ST_LOCKED : ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (!sel_match) begin
          cnt_nxt   = '0;
          state_nxt = ST_SEARCH;
        end else begin
          cnt_nxt = (match_cnt >= LOCK_CNT) ? LOCK_CNT : match_cnt + MATCH_CNT_W'(1);
          if (match_cnt + MATCH_CNT_W'(1) >= LOCK_CNT) state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: state_nxt = ST_LOCKED;
    endcase
    if (relock) begin
      state_nxt = ST_SEARCH;
      cnt_nxt   = '0;
      sel_nxt   = align_sel;
    end
    if (!enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      sel_nxt   = align_sel;
    end
  end

  // Registered outputs follow the state being entered, so the final sync word is the first payload.
  always_comb begin
    lock_nxt = (state_nxt == ST_LOCKED);
    data_nxt = lock_nxt ? cand[sel_nxt] : '0;
  end

`ifdef SLINK_GPIO_RX_ALIGN_STATUS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      relock_cnt  <= '0;
      verify_fail <= 1'b0;
    end else begin
      verify_fail <= enable && !relock && (state == ST_VERIFY) && !sel_match;
      if ((state == ST_LOCKED) && (state_nxt != ST_LOCKED) && (relock_cnt != 8'hFF))
        relock_cnt <= relock_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_slink_gpio_rx_align.sv
// tb/tb_slink_gpio_rx_align.sv - randomized bench for slink_gpio_rx_align against a word-level reference model
module tb_slink_gpio_rx_align;

  localparam logic [7:0] SYNC = 8'hB5;
  localparam int         LOCK = 4;

  logic       clk = 1'b0;
  logic       rst, en, rl, en2;
  logic [7:0] par, par2;
  logic [7:0] data, data2;
  logic       valid, lck, valid2, lck2;
  logic [2:0] sel;
  logic [1:0] sel2;
`ifdef SLINK_GPIO_RX_ALIGN_STATUS_EN
  logic [7:0] rcnt, rcnt2;
  logic       vfail, vfail2;
`endif

  always #5 clk = ~clk;

  slink_gpio_rx_align #(.PAR_DATA_WIDTH(8), .IO_DATA_WIDTH(1), .SYNC_PATTERN(SYNC), .LOCK_COUNT(LOCK)) dut (
    .clk(clk), .reset(rst), .enable(en), .relock(rl), .rx_par_data(par),
    .rx_data(data), .rx_data_valid(valid), .locked(lck), .align_sel(sel)
`ifdef SLINK_GPIO_RX_ALIGN_STATUS_EN
    , .relock_cnt(rcnt), .verify_fail(vfail)
`endif
  );

  slink_gpio_rx_align #(.PAR_DATA_WIDTH(8), .IO_DATA_WIDTH(2), .SYNC_PATTERN(SYNC), .LOCK_COUNT(LOCK)) dut2 (
    .clk(clk), .reset(rst), .enable(en2), .relock(1'b0), .rx_par_data(par2),
    .rx_data(data2), .rx_data_valid(valid2), .locked(lck2), .align_sel(sel2)
`ifdef SLINK_GPIO_RX_ALIGN_STATUS_EN
    , .relock_cnt(rcnt2), .verify_fail(vfail2)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 hunting, 2 qualifying, 3 locked.
  int         m_mode, m_cnt, m_sel, e_sel, e_rcnt;
  logic [7:0] m_prev, e_data;
  logic       e_valid, e_vfail;

  function automatic logic [7:0] cand_of(logic [7:0] cur, logic [7:0] prev, int k);
    logic [15:0] w;
    w = {cur, prev} >> k;
    return w[7:0];
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int r);
    logic [15:0] t;
    t = {v, v} << r;
    return t[15:8];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_sel = 0; m_prev = 8'h00;
    e_sel = 0; e_rcnt = 0; e_data = 8'h00; e_valid = 1'b0; e_vfail = 1'b0;
  endtask

  task automatic model_step();
    int hit;
    int nm;
    hit = -1;
    for (int k = 0; k < 8; k++)
      if (hit < 0 && cand_of(par, m_prev, k) == SYNC) hit = k;
    nm = m_mode;
    e_vfail = 1'b0;
    if (!en) begin
      nm = 0; m_cnt = 0;
    end else if (rl) begin
      nm = 1; m_cnt = 0;
    end else if (m_mode == 0) begin
      nm = 1;
    end else if (m_mode == 1) begin
      if (hit >= 0) begin
        m_sel = hit; m_cnt = 1; nm = (LOCK == 1) ? 3 : 2;
      end
    end else if (m_mode == 2) begin
      if (cand_of(par, m_prev, m_sel) == SYNC) begin
        m_cnt++;
        if (m_cnt >= LOCK) nm = 3;
      end else begin
        m_cnt = 0; nm = 1; e_vfail = 1'b1;
      end
    end
    if (m_mode == 3 && nm != 3 && e_rcnt < 255) e_rcnt++;
    m_mode  = nm;
    e_valid = (nm == 3);
    e_data  = e_valid ? cand_of(par, m_prev, m_sel) : 8'h00;
    e_sel   = m_sel;
    m_prev  = par;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("rx_data", 32'(data), 32'(e_data));
    check("rx_data_valid", 32'(valid), 32'(e_valid));
    check("locked", 32'(lck), 32'(e_valid));
    check("align_sel", 32'(sel), 32'(e_sel));
`ifdef SLINK_GPIO_RX_ALIGN_STATUS_EN
    check("relock_cnt", 32'(rcnt), 32'(e_rcnt));
    check("verify_fail", 32'(vfail), 32'(e_vfail));
`endif
  endtask

  task automatic cycle(logic e, logic r, logic [7:0] d);
    en = e; rl = r; par = d;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    int len, mode, rot;
    rst = 1'b1; en = 1'b0; rl = 1'b0; par = 8'h00; en2 = 1'b0; par2 = 8'h5B;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_locked", 32'(lck), 32'h0);
    check("reset_sel", 32'(sel), 32'h0);
    rst = 1'b0;

    // Sync rotated by 3 lanes (0xAD); 4 matches, lock on the 5th enabled edge.
    cycle(1'b0, 1'b0, 8'hAD);
    en2 = 1'b1;
    repeat (4) cycle(1'b1, 1'b0, 8'hAD);
    check("t1_not_yet_locked", 32'(lck), 32'h0);
    check("t6_not_yet_locked", 32'(lck2), 32'h0);
    cycle(1'b1, 1'b0, 8'hAD);
    check("t1_locked", 32'(lck), 32'h1);
    check("t1_sel", 32'(sel), 32'h3);
    check("t1_data", 32'(data), 32'hB5);
    check("t6_locked", 32'(lck2), 32'h1);
    check("t6_sel", 32'(sel2), 32'h2);
    check("t6_data", 32'(data2), 32'hB5);
    en2 = 1'b0;

    // Payload passes through aligned.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    check("t2_data00", 32'(data), 32'h00);
    cycle(1'b1, 1'b0, 8'h88);
    cycle(1'b1, 1'b0, 8'h88);
    check("t2_data11", 32'(data), 32'h11);
    check("t2_valid", 32'(valid), 32'h1);

    // Corrupt word while qualifying.
    cycle(1'b1, 1'b1, 8'hAD);
    cycle(1'b1, 1'b0, 8'hAD);
    cycle(1'b1, 1'b0, 8'hAD);
    cycle(1'b1, 1'b0, 8'h00);
    check("t3_after_corrupt", 32'(lck), 32'h0);
`ifdef SLINK_GPIO_RX_ALIGN_STATUS_EN
    check("t3_verify_fail", 32'(vfail), 32'h1);
`endif
    repeat (4) cycle(1'b1, 1'b0, 8'hAD);
    check("t3_relock_pending", 32'(lck), 32'h0);
    cycle(1'b1, 1'b0, 8'hAD);
    check("t3_relocked", 32'(lck), 32'h1);

    // Relock onto rotation 5 (0xB6).
    cycle(1'b1, 1'b1, 8'hB6);
    check("t4_dropped", 32'(lck), 32'h0);
    repeat (5) cycle(1'b1, 1'b0, 8'hB6);
    check("t4_locked", 32'(lck), 32'h1);
    check("t4_sel", 32'(sel), 32'h5);
`ifdef SLINK_GPIO_RX_ALIGN_STATUS_EN
    check("t4_relock_cnt", 32'(rcnt), 32'h2);
`endif

    // Enable drop, then async reset in the middle of qualification.
    cycle(1'b0, 1'b0, 8'hB6);
    check("t5_idle_valid", 32'(valid), 32'h0);
    check("t5_idle_data", 32'(data), 32'h0);
    repeat (3) cycle(1'b1, 1'b0, 8'hB6);
    rst = 1'b1;
    #1;
    check("t5_rst_data", 32'(data), 32'h0);
    check("t5_rst_valid", 32'(valid), 32'h0);
    check("t5_rst_locked", 32'(lck), 32'h0);
    check("t5_rst_sel", 32'(sel), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized bursts of rotated sync, noise and control events.
    for (int b = 0; b < 120; b++) begin
      len  = $urandom_range(8, 30);
      mode = $urandom_range(0, 3);
      rot  = $urandom_range(0, 7);
      for (int i = 0; i < len; i++) begin
        logic [7:0] d;
        if (mode == 0) d = 8'($urandom);
        else if (mode == 3 && $urandom_range(0, 9) == 0) d = 8'($urandom);
        else d = rotl8(SYNC, rot);
        cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 49) == 0), d);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
